// File: rtl/display_scan_ctrl.sv
// Scan scheduler for a multiplexed seven-segment display: one digit driven at a
// time, with a blanking gap before each digit to keep segments from ghosting.
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 600
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       digit_data,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
    output logic [3:0]                    nibble,
    output logic [NUM_DIGITS-1:0]         digit_en_n,
    output logic                          frame_tick
);
    localparam int SW   = $clog2(NUM_DIGITS);
    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [SW-1:0] SEL_LAST   = SW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [3:0]            nib_q, nib_d;
    logic [NUM_DIGITS-1:0] en_n_q, en_n_d;
    logic                  tick_q, tick_d;

    logic                  wrap;
    logic [SW-1:0]         sel_nx;
    logic [3:0]            nib_nx;

    // Next digit in scan order, wrapping on the digit count rather than the field width.
    assign wrap   = (sel_q == SEL_LAST);
    assign sel_nx = wrap ? '0 : sel_q + SW'(1);

    always_comb begin
        nib_nx = digit_data[3:0];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_nx == SW'(i)) begin
                nib_nx = digit_data[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            nib_q   <= '0;
            en_n_q  <= '1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            nib_q   <= nib_d;
            en_n_q  <= en_n_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        nib_d   = nib_q;
        en_n_d  = en_n_q;
        tick_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                en_n_d = '1;
                if (en) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    sel_d   = '0;
                    nib_d   = digit_data[3:0];
                end
            end
            BLANK: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sel_d   = '0;
                    en_n_d  = '1;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    en_n_d  = ~(NUM_DIGITS'(1) << sel_q);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRIVE: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sel_d   = '0;
                    en_n_d  = '1;
                end else if (cnt_q == DWELL_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    sel_d   = sel_nx;
                    nib_d   = nib_nx;
                    en_n_d  = '1;
                    tick_d  = wrap;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sel_d   = '0;
                en_n_d  = '1;
            end
        endcase
    end

    assign digit_sel  = sel_q;
    assign nibble     = nib_q;
    assign digit_en_n = en_n_q;
    assign frame_tick = tick_q;

endmodule
